// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage_if
// Description : ALU result stage bus: producer handshake, consumer handshake
//               and status/debug signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_stage_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
);
    localparam int C_LVL_W = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_F;
    logic               in_Cout;
    logic [3:0]         in_sel;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_F;
    logic [2:0]         out_flags;
    logic [3:0]         out_sel;

    logic [C_LVL_W-1:0] level;
    logic [2:0]         sticky_flags;
    logic               sticky_clr;
    logic [CNT_W-1:0]   result_count;

    // The result stage itself
    modport slave (
        input  in_valid, in_F, in_Cout, in_sel, out_ready, sticky_clr,
        output in_ready, out_valid, out_F, out_flags, out_sel,
               level, sticky_flags, result_count
    );

    // Producer/consumer/status side
    modport master (
        output in_valid, in_F, in_Cout, in_sel, out_ready, sticky_clr,
        input  in_ready, out_valid, out_F, out_flags, out_sel,
               level, sticky_flags, result_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Registered ALU result stage: FIFO-buffered results with
//               N/Z/C flags, sticky flags and an accepted-result counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_result_stage_if.slave   bus
);
    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_LVL_W = $clog2(DEPTH) + 1;
    localparam logic [C_LVL_W-1:0] C_FULL = C_LVL_W'(DEPTH);
    localparam logic [C_PTR_W-1:0] C_LAST = C_PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem_f     [DEPTH];
    logic [2:0]         r_mem_flags [DEPTH];
    logic [3:0]         r_mem_sel   [DEPTH];

    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_LVL_W-1:0] r_level;
    logic [2:0]         r_sticky;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_wr;
    logic               w_rd;
    logic [2:0]         w_flags;
    logic [C_PTR_W-1:0] w_wr_ptr_nxt;
    logic [C_PTR_W-1:0] w_rd_ptr_nxt;

    // Ready comes only from registered level, so no out_ready -> in_ready path
    always_comb begin
        w_full       = (r_level == C_FULL);
        w_empty      = (r_level == '0);
        w_wr         = bus.in_valid && !w_full;
        w_rd         = bus.out_ready && !w_empty;
        // Carry is meaningful only for the arithmetic sel group
        w_flags      = {bus.in_F[WIDTH-1],
                        (bus.in_F == '0),
                        bus.in_Cout && (bus.in_sel[3:2] == 2'b00)};
        w_wr_ptr_nxt = (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + C_PTR_W'(1);
        w_rd_ptr_nxt = (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + C_PTR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_f[i]     <= '0;
                r_mem_flags[i] <= '0;
                r_mem_sel[i]   <= '0;
            end
        end else if (w_wr) begin
            r_mem_f[r_wr_ptr]     <= bus.in_F;
            r_mem_flags[r_wr_ptr] <= w_flags;
            r_mem_sel[r_wr_ptr]   <= bus.in_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + C_LVL_W'(1);
                2'b01:   r_level <= r_level - C_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A clear coinciding with a write keeps that write's flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= '0;
            r_count  <= '0;
        end else begin
            if (bus.sticky_clr) begin
                r_sticky <= w_wr ? w_flags : 3'b000;
            end else if (w_wr) begin
                r_sticky <= r_sticky | w_flags;
            end
            if (w_wr) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready     = !w_full;
    assign bus.out_valid    = !w_empty;
    assign bus.out_F        = r_mem_f[r_rd_ptr];
    assign bus.out_flags    = r_mem_flags[r_rd_ptr];
    assign bus.out_sel      = r_mem_sel[r_rd_ptr];
    assign bus.level        = r_level;
    assign bus.sticky_flags = r_sticky;
    assign bus.result_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Scoreboard bench for alu_result_stage with directed scenarios
//               and randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [31:0] f;
        logic [2:0]  flags;
        logic [3:0]  sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int          errors = 0;
    int          checks = 0;
    exp_t        q[$];
    logic [2:0]  m_sticky = 3'b000;
    logic [15:0] m_count  = 16'h0000;

    alu_result_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_flags(input logic [31:0] f, input logic c, input logic [3:0] s);
        logic n, z, cc;
        n  = (f >= 32'h8000_0000);
        z  = (f == 32'd0);
        cc = c && (s < 4'd4);
        return {n, z, cc};
    endfunction

    // Reference model and scoreboard, sampled mid-cycle
    always @(negedge clk) begin : monitor
        int       sz;
        logic     wr, rd;
        logic [2:0] nf;
        exp_t     e;
        if (rst) begin
            q.delete();
            m_sticky = 3'b000;
            m_count  = 16'h0000;
        end else begin
            sz = q.size();
            chk("out_valid", 32'(bus.out_valid), 32'(sz != 0));
            chk("in_ready", 32'(bus.in_ready), 32'(sz < DEPTH));
            chk("level", 32'(bus.level), 32'(sz));
            chk("sticky_flags", 32'(bus.sticky_flags), 32'(m_sticky));
            chk("result_count", 32'(bus.result_count), 32'(m_count));
            if (sz > 0) begin
                chk("out_F", bus.out_F, q[0].f);
                chk("out_flags", 32'(bus.out_flags), 32'(q[0].flags));
                chk("out_sel", 32'(bus.out_sel), 32'(q[0].sel));
            end
            wr = bus.in_valid && (sz < DEPTH);
            rd = bus.out_ready && (sz > 0);
            nf = ref_flags(bus.in_F, bus.in_Cout, bus.in_sel);
            if (rd) void'(q.pop_front());
            if (wr) begin
                e.f = bus.in_F; e.flags = nf; e.sel = bus.in_sel;
                q.push_back(e);
                m_count = m_count + 16'd1;
            end
            if (bus.sticky_clr) m_sticky = wr ? nf : 3'b000;
            else if (wr)        m_sticky = m_sticky | nf;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] f, input logic c, input logic [3:0] s);
        bus.in_valid = v;
        bus.in_F     = f;
        bus.in_Cout  = c;
        bus.in_sel   = s;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_level"}, 32'(bus.level), 32'd0);
        chk({tag, "_out_F"}, bus.out_F, 32'd0);
        chk({tag, "_out_flags"}, 32'(bus.out_flags), 32'd0);
        chk({tag, "_out_sel"}, 32'(bus.out_sel), 32'd0);
        chk({tag, "_sticky"}, 32'(bus.sticky_flags), 32'd0);
        chk({tag, "_count"}, 32'(bus.result_count), 32'd0);
    endtask

    task automatic single_write_zero(input string tag);
        bus.out_ready = 1'b1;
        set_in(1'b1, 32'h0, 1'b1, 4'b0000);
        step();
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_flags"}, 32'(bus.out_flags), 32'b011);
        chk({tag, "_count"}, 32'(bus.result_count), 32'd1);
        bus.in_valid = 1'b0;
        step();
        chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin : stim
        logic [15:0] c0;
        int          n;
        int          r;
        set_in(1'b0, 32'h0, 1'b0, 4'h0);
        bus.out_ready  = 1'b0;
        bus.sticky_clr = 1'b0;
        repeat (2) step();
        chk_reset_values("rst");
        rst = 1'b0;
        step();

        single_write_zero("s1");

        // Logic op masks carry; clear collides with the write
        set_in(1'b1, 32'h8000_0000, 1'b1, 4'b0100);
        bus.sticky_clr = 1'b1;
        step();
        chk("s2_flags", 32'(bus.out_flags), 32'b100);
        chk("s2_sticky", 32'(bus.sticky_flags), 32'b100);
        bus.in_valid = 1'b0; bus.sticky_clr = 1'b0;
        step();

        // Fill and stall
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h11, 1'b0, 4'h1); step();
        set_in(1'b1, 32'h22, 1'b0, 4'h2); step();
        chk("s3_level_full", 32'(bus.level), 32'd2);
        chk("s3_in_ready", 32'(bus.in_ready), 32'd0);
        set_in(1'b1, 32'h33, 1'b0, 4'h3); step();
        chk("s3_held_level", 32'(bus.level), 32'd2);
        chk("s3_head_stable", bus.out_F, 32'h11);
        bus.out_ready = 1'b1; step();
        chk("s3_pop1", bus.out_F, 32'h22);
        chk("s3_ready_back", 32'(bus.in_ready), 32'd1);
        step();
        chk("s3_pop2", bus.out_F, 32'h33);
        chk("s3_level1", 32'(bus.level), 32'd1);
        bus.in_valid = 1'b0; step();
        chk("s3_empty", 32'(bus.level), 32'd0);

        // Simultaneous read/write at level 1
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h100, 1'b1, 4'h0); step();
        bus.out_ready = 1'b1;
        c0 = m_count;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 32'h200 + 32'(i), 1'b1, 4'(i));
            step();
            chk("s4_level", 32'(bus.level), 32'd1);
        end
        chk("s4_count_delta", 32'(bus.result_count), 32'(c0 + 16'd8));
        bus.in_valid = 1'b0; step(); step();

        // Sticky clear collisions
        bus.sticky_clr = 1'b1;
        set_in(1'b1, 32'h0, 1'b0, 4'b1000); step();
        chk("s5_clr_wr", 32'(bus.sticky_flags), 32'b010);
        bus.in_valid = 1'b0; step();
        chk("s5_clr_only", 32'(bus.sticky_flags), 32'b000);
        bus.sticky_clr = 1'b0; step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 3));
            set_in(1'($urandom_range(0, 3) != 0),
                   (r == 0) ? 32'h0 : (r == 1) ? (32'h8000_0000 | $urandom) : $urandom,
                   1'($urandom), 4'($urandom));
            bus.out_ready  = 1'($urandom_range(0, 2) != 0);
            bus.sticky_clr = 1'($urandom_range(0, 15) == 0);
            step();
        end
        bus.in_valid = 1'b0; bus.sticky_clr = 1'b0; bus.out_ready = 1'b1;
        repeat (3) step();

        // Async reset in the middle of a cycle with two entries held
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'hAAAA_0001, 1'b1, 4'h5); step();
        set_in(1'b1, 32'hAAAA_0002, 1'b1, 4'h6); step();
        chk("s6_level_pre", 32'(bus.level), 32'd2);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_reset_values("async");
        step();
        rst = 1'b0;
        step();
        single_write_zero("s6_after");

        // Counter wrap
        bus.out_ready = 1'b1;
        n = int'(16'hFFFF - m_count);
        for (int i = 0; i < n; i++) begin
            set_in(1'b1, $urandom, 1'($urandom), 4'($urandom));
            step();
        end
        chk("wrap_pre", 32'(bus.result_count), 32'hFFFF);
        set_in(1'b1, 32'h1234, 1'b0, 4'h9); step();
        chk("wrap_zero", 32'(bus.result_count), 32'h0);
        bus.in_valid = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result stage that sits directly downstream of the 32-bit ALU datapath. It captures each ALU result (F, Cout, sel) under a valid/ready handshake and derives N/Z/C status flags. Results are buffered in a small FIFO so the consumer can stall without dropping data. The block also keeps sticky flags and a result counter for status and debug.

## Interface
Parameters:
- WIDTH, 32, datapath width; must match the ALU F width.
- DEPTH, 2, FIFO entries; power of 2, ≥2.
- CNT_W, 16, width of the accepted-result counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  ALU result on in_F/in_Cout/in_sel is valid this cycle.
- in_ready  out  1  stage can accept; equals !full.
- in_F  in  WIDTH  ALU result F.
- in_Cout  in  1  ALU carry out.
- in_sel  in  4  ALU sel used to produce in_F.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  consumer takes head entry.
- out_F  out  WIDTH  head entry result.
- out_flags  out  3  head entry flags {N,Z,C}.
- out_sel  out  4  head entry sel.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- sticky_flags  out  3  OR of {N,Z,C} of all results accepted since reset or clear.
- sticky_clr  in  1  synchronous clear of sticky_flags.
- result_count  out  CNT_W  number of accepted results, wraps modulo 2^CNT_W.

## Operation
- Accept (write) when in_valid && in_ready; pop (read) when out_valid && out_ready.
- Flags are computed at write time from the input and stored with the entry:
  - N = in_F[WIDTH-1].
  - Z = (in_F == 0).
  - C = in_Cout && (in_sel[3:2] == 2'b00); C is forced to 0 for non-arithmetic sel, even if in_Cout=1.
- FIFO: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping at DEPTH-1 -> 0, plus a level counter.
  - full = (level == DEPTH); empty = (level == 0).
  - Write-only: level+1. Read-only: level-1. Simultaneous write and read: level unchanged, both pointers advance.
  - When full, in_ready=0 in the same cycle, even if out_ready=1. There is no full pass-through. in_valid while full is ignored; no state changes.
  - When empty, a read has no effect; out_valid=0 guarantees this.
- out_F/out_flags/out_sel are driven from the storage at rd_ptr. They must be stable while out_valid=1 and out_ready=0.
- Sticky update each cycle:
  - sticky_clr=1 with a write: sticky_flags <= new entry flags.
  - sticky_clr=1 without a write: sticky_flags <= 0.
  - Otherwise: sticky_flags <= sticky_flags | (write ? new flags : 0).
- result_count increments on every write. It wraps from 2^CNT_W-1 to 0 and is unaffected by reads or sticky_clr.

## Timing
- Reset (async assert, any cycle, including mid-transfer):
  - level=0, pointers=0, out_valid=0, in_ready=1.
  - out_F=0, out_flags=0, out_sel=0, sticky_flags=0, result_count=0.
  - Storage contents are cleared to 0.
- Write latency: an entry accepted at edge k is visible on out_* with out_valid=1 from edge k onward, i.e. the next cycle. There is no combinational in->out path.
- in_ready depends only on registered level. It never depends on out_ready or in_valid in the same cycle.
- A pop at edge k exposes the next entry (or out_valid=0) after edge k.
- Throughput is 1 result/cycle when out_ready is held high. Consumer stalls are absorbed up to DEPTH entries, then in_ready drops.
- sticky_flags, result_count and level are registered and update at the same edge as the write/read that causes them.

## Test plan
- Reset then single write, in_F=0x00000000, in_Cout=1, in_sel=4'b0000, out_ready=1:
  - next cycle out_valid=1, out_flags={N0,Z1,C1}, result_count=1.
  - the following cycle out_valid=0.
- Logic op carry masking, in_F=0x80000000, in_Cout=1, in_sel=4'b0100:
  - out_flags={N1,Z0,C0}; sticky_flags=3'b100.
- Fill/stall with out_ready=0 and back-to-back writes 0x11,0x22,0x33:
  - first two accepted, level=2, in_ready=0; third held.
  - raise out_ready: pops 0x11 then 0x22 in order; 0x33 is accepted the cycle after in_ready returns.
- Full plus simultaneous read/write at level=1, in_valid=1, out_ready=1 for 8 cycles with incrementing data:
  - level stays 1, outputs in order, pointers wrap, result_count advances by 8.
- Sticky clear collisions:
  - sticky_clr with write of Z-result -> sticky_flags=3'b010.
  - sticky_clr alone -> 0.
  - result_count preset near 0xFFFF by 65535 writes wraps to 0 on the next write.
- Async reset asserted mid-cycle with level=2: all outputs go to reset values immediately, without waiting for a clock edge; after release, the first write behaves as in scenario 1.
